stairs_animator: RTL and testbench

- Parametrised successor to the single-block stair animator.
- Draws a BLK_W x BLK_H rectangle at a latched (x, y) base, one pixel per clock, onto the VGA adapter plot interface.
- Holds the rectangle for FRAMES frame ticks, erases it with a background colour, then steps it vertically by STEP rows.
- Supports up/down direction and wraps at programmable screen bounds; sits between the game top level and the vga_adapter.

---
 rtl/stairs_animator.sv | 229 ++++++++++++++++++++++
 tb/tb_stairs_animator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stairs_animator.sv
// Stair-step rectangle animator feeding the vga_adapter plot interface: draw, hold, erase, step.
// Optional STAIRS_ANIM_BOUNCE_EN: clamp at the screen bounds and reverse direction instead of wrapping.
module stairs_animator #(
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 7,
    parameter int unsigned BLK_W  = 40,
    parameter int unsigned BLK_H  = 10,
    parameter int unsigned DELAY  = 833333,
    parameter int unsigned FRAMES = 15,
    parameter int unsigned STEP   = 1,
    parameter int unsigned Y_MIN  = 0,
    parameter int unsigned Y_MAX  = 119
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           go,
    input  logic           stop,
    input  logic           dir,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    input  logic [2:0]     colour,
    input  logic [2:0]     bg_colour,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [2:0]     out_colour,
    output logic           plot,
    output logic           busy,
    output logic           step_done,
    output logic           wrapped
);

    localparam int unsigned Y_TOP = Y_MAX - BLK_H + 1;
    localparam int unsigned PX_W  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int unsigned PY_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int unsigned DLY_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [2:0]     col_q, col_d;
    logic           dir_q, dir_d;
    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [FRM_W-1:0] frm_q, frm_d;

    logic [X_W-1:0] out_x_q, out_x_d;
    logic [Y_W-1:0] out_y_q, out_y_d;
    logic [2:0]     out_col_q, out_col_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           step_done_q, step_done_d;
    logic           wrapped_q, wrapped_d;

    logic           scan_last;
    logic           wrap_hit;
    logic [Y_W-1:0] y_mv;
    logic           dir_mv;
    logic [31:0]    y_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            dir_q       <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            dly_q       <= '0;
            frm_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_col_q   <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            dir_q       <= dir_d;
            px_q        <= px_d;
            py_q        <= py_d;
            dly_q       <= dly_d;
            frm_q       <= frm_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_col_q   <= out_col_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            wrapped_q   <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        dir_d     = dir_q;
        px_d      = px_q;
        py_d      = py_q;
        dly_d     = dly_q;
        frm_d     = frm_q;
        scan_last = (px_q == PX_W'(BLK_W - 1)) && (py_q == PY_W'(BLK_H - 1));

        // Target base row for the next MOVE; only depends on latched y/dir.
        y_ext    = 32'(y_q);
        wrap_hit = 1'b0;
        y_mv     = y_q;
        dir_mv   = dir_q;
        if (!dir_q) begin
            if (y_ext < Y_MIN + STEP) begin
                wrap_hit = 1'b1;
`ifdef STAIRS_ANIM_BOUNCE_EN
                y_mv   = Y_W'(Y_MIN);
                dir_mv = 1'b1;
`else
                y_mv   = Y_W'(Y_TOP);
`endif
            end else begin
                y_mv = y_q - Y_W'(STEP);
            end
        end else begin
            if (y_ext + STEP > Y_TOP) begin
                wrap_hit = 1'b1;
`ifdef STAIRS_ANIM_BOUNCE_EN
                y_mv   = Y_W'(Y_TOP);
                dir_mv = 1'b0;
`else
                y_mv   = Y_W'(Y_MIN);
`endif
            end else begin
                y_mv = y_q + Y_W'(STEP);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_DRAW;
                    x_d     = in_x;
                    y_d     = in_y;
                    col_d   = colour;
                    dir_d   = dir;
                end
            end
            S_DRAW, S_ERASE: begin
                if (px_q == PX_W'(BLK_W - 1)) begin
                    px_d = '0;
                    if (py_q == PY_W'(BLK_H - 1)) begin
                        py_d = '0;
                    end else begin
                        py_d = py_q + PY_W'(1);
                    end
                end else begin
                    px_d = px_q + PX_W'(1);
                end
                if (scan_last) begin
                    if (state_q == S_DRAW) begin
                        state_d = S_WAIT;
                        dly_d   = DLY_W'(DELAY - 1);
                        frm_d   = '0;
                    end else begin
                        state_d = S_MOVE;
                    end
                end
            end
            S_WAIT: begin
                if (dly_q == '0) begin
                    dly_d = DLY_W'(DELAY - 1);
                    if (frm_q == FRM_W'(FRAMES - 1)) begin
                        frm_d   = '0;
                        state_d = S_ERASE;
                    end else begin
                        frm_d = frm_q + FRM_W'(1);
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_MOVE: begin
                y_d     = y_mv;
                dir_d   = dir_mv;
                state_d = stop ? S_IDLE : S_DRAW;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are computed from next-state values so they line up with the state register.
        plot_d      = (state_d == S_DRAW) || (state_d == S_ERASE);
        busy_d      = (state_d != S_IDLE);
        step_done_d = (state_d == S_MOVE);
        wrapped_d   = (state_d == S_MOVE) && wrap_hit;
        out_x_d     = plot_d ? (x_d + X_W'(px_d)) : '0;
        out_y_d     = plot_d ? (y_d + Y_W'(py_d)) : '0;
        if (state_d == S_DRAW) begin
            out_col_d = col_d;
        end else if (state_d == S_ERASE) begin
            out_col_d = bg_colour;
        end else begin
            out_col_d = '0;
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_col_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign step_done  = step_done_q;
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_stairs_animator.sv
// Scoreboard bench for stairs_animator: stimulus queues expected pixels, gaps and moves; a monitor pops them.
module tb_stairs_animator;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned BLK_W    = 4;
    localparam int unsigned BLK_H    = 2;
    localparam int unsigned DELAY    = 3;
    localparam int unsigned FRAMES   = 2;
    localparam int unsigned STEP     = 3;
    localparam int unsigned Y_MIN    = 0;
    localparam int unsigned Y_MAX    = 119;
    localparam int          WAIT_CYC = 6;

    logic           clock;
    logic           reset;
    logic           go;
    logic           stop;
    logic           dir;
    logic [X_W-1:0] in_x;
    logic [Y_W-1:0] in_y;
    logic [2:0]     colour;
    logic [2:0]     bg_colour;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic [2:0]     out_colour;
    logic           plot;
    logic           busy;
    logic           step_done;
    logic           wrapped;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [2:0]     c;
    } pix_t;

    pix_t pix_q[$];
    bit   move_q[$];
    int   gap_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   gap      = 0;

    stairs_animator #(
        .X_W(X_W), .Y_W(Y_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .DELAY(DELAY),
        .FRAMES(FRAMES), .STEP(STEP), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .stop(stop), .dir(dir),
        .in_x(in_x), .in_y(in_y), .colour(colour), .bg_colour(bg_colour),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .plot(plot), .busy(busy), .step_done(step_done), .wrapped(wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every plotted pixel, every plot-free gap inside a run, every MOVE pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (plot) begin
                if (gap > 0) begin
                    if (gap_q.size() == 0) chk("unexpected_gap", gap, 0);
                    else chk("gap_len", gap, gap_q.pop_front());
                end
                gap = 0;
                if (pix_q.size() == 0) begin
                    chk("unexpected_pixel", int'({out_x, out_y, out_colour}), -1);
                end else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    chk("pix_x", int'(out_x), int'(e.x));
                    chk("pix_y", int'(out_y), int'(e.y));
                    chk("pix_colour", int'(out_colour), int'(e.c));
                end
            end else if (busy) begin
                gap = gap + 1;
            end else begin
                gap = 0;
            end
            if (step_done) begin
                if (move_q.size() == 0) chk("unexpected_step", 1, 0);
                else chk("wrapped", int'(wrapped), int'(move_q.pop_front()));
            end else if (wrapped) begin
                chk("wrapped_without_step", 1, 0);
            end
        end
    end

    task automatic push_block(input int x, input int y, input logic [2:0] c, input logic [2:0] bg);
        pix_t p;
        for (int r = 0; r < int'(BLK_H); r++)
            for (int k = 0; k < int'(BLK_W); k++) begin
                p.x = X_W'(x + k); p.y = Y_W'(y + r); p.c = c;
                pix_q.push_back(p);
            end
        gap_q.push_back(WAIT_CYC);
        for (int r = 0; r < int'(BLK_H); r++)
            for (int k = 0; k < int'(BLK_W); k++) begin
                p.x = X_W'(x + k); p.y = Y_W'(y + r); p.c = bg;
                pix_q.push_back(p);
            end
    endtask

    task automatic wait_step(input string name, output int at);
        bit found;
        found = 1'b0;
        at = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (step_done) begin
                found = 1'b1;
                at = cyc;
            end
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic start(input int x, input int y, input bit d, input logic [2:0] c,
                         input logic [2:0] bg, input bit stp, output int g);
        @(negedge clock);
        in_x = X_W'(x); in_y = Y_W'(y); dir = d; colour = c; bg_colour = bg; stop = stp; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        g = cyc;
        // scramble inputs to prove they were latched
        in_x = 8'hEE; in_y = 7'h55; dir = ~d; colour = ~c;
    endtask

    // Two animation periods, stop requested during the second; optional ignored go during WAIT.
    task automatic run_two(input string name, input int x, input int y, input bit d,
                           input logic [2:0] c, input logic [2:0] bg,
                           input int y2, input bit w1, input bit w2, input bit go_in_wait);
        int g, s1, s2;
        push_block(x, y, c, bg);
        move_q.push_back(w1);
        gap_q.push_back(1);
        push_block(x, y2, c, bg);
        move_q.push_back(w2);
        start(x, y, d, c, bg, 1'b0, g);
        wait_step(name, s1);
        chk({name, "_go_to_step"}, s1 - g, 22);
        repeat (2) @(negedge clock);
        stop = 1'b1;
        if (go_in_wait) begin
            repeat (8) @(negedge clock);
            in_x = 8'd99; in_y = 7'd7; go = 1'b1;
            @(negedge clock);
            go = 1'b0;
        end
        wait_step(name, s2);
        chk({name, "_period"}, s2 - s1, 23);
        @(negedge clock);
        chk({name, "_busy_after_stop"}, int'(busy), 0);
        chk({name, "_plot_after_stop"}, int'(plot), 0);
        stop = 1'b0;
    endtask

    initial begin
        int g, s;
        reset = 1'b1; go = 1'b0; stop = 1'b0; dir = 1'b0;
        in_x = '0; in_y = '0; colour = '0; bg_colour = '0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", int'({out_x, out_y, out_colour, plot, busy, step_done, wrapped}), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", int'(busy), 0);

        // Basic draw/wait/erase, single period with stop already held
        push_block(10, 20, 3'b010, 3'b000);
        move_q.push_back(1'b0);
        start(10, 20, 1'b0, 3'b010, 3'b000, 1'b1, g);
        wait_step("basic", s);
        chk("basic_go_to_step", s - g, 22);
        @(negedge clock);
        chk("basic_busy_idle", int'(busy), 0);

`ifdef STAIRS_ANIM_BOUNCE_EN
        run_two("up_wrap",    10, 0,   1'b0, 3'b010, 3'b000, 0,   1'b1, 1'b0, 1'b0);
        run_two("down_stop",  20, 50,  1'b1, 3'b111, 3'b101, 53,  1'b0, 1'b0, 1'b1);
        run_two("down_wrap",  30, 118, 1'b1, 3'b100, 3'b001, 118, 1'b1, 1'b0, 1'b0);
        run_two("down_edge",  40, 115, 1'b1, 3'b011, 3'b000, 118, 1'b0, 1'b1, 1'b0);
        run_two("up_edge",    50, 3,   1'b0, 3'b110, 3'b010, 0,   1'b0, 1'b1, 1'b0);
`else
        run_two("up_wrap",    10, 0,   1'b0, 3'b010, 3'b000, 118, 1'b1, 1'b0, 1'b0);
        run_two("down_stop",  20, 50,  1'b1, 3'b111, 3'b101, 53,  1'b0, 1'b0, 1'b1);
        run_two("down_wrap",  30, 118, 1'b1, 3'b100, 3'b001, 0,   1'b1, 1'b0, 1'b0);
        run_two("down_edge",  40, 115, 1'b1, 3'b011, 3'b000, 118, 1'b0, 1'b1, 1'b0);
        run_two("up_edge",    50, 3,   1'b0, 3'b110, 3'b010, 0,   1'b0, 1'b1, 1'b0);
`endif

        // Reset mid-DRAW: outputs clear immediately, nothing plots afterwards
        push_block(60, 30, 3'b101, 3'b000);
        start(60, 30, 1'b0, 3'b101, 3'b000, 1'b0, g);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_outputs", int'({out_x, out_y, out_colour, step_done, wrapped}), 0);
        pix_q.delete();
        gap_q.delete();
        move_q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("rst_release_busy", int'(busy), 0);

        chk("pix_queue_empty", pix_q.size(), 0);
        chk("move_queue_empty", move_q.size(), 0);
        chk("gap_queue_empty", gap_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
